// File: rtl/loss_accumulator.sv
// loss_accumulator: batch reducer for per-element L1 losses.
// Sums batch_len unsigned losses into a saturated batch sum and holds the
// result behind a valid/ready handshake.
// Optional feature macro: LOSS_MEAN_EN adds a restoring divider state (DIV)
// that produces floor(sum/batch_len); without it loss_mean is tied to zero.
module loss_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  batch_len,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] loss_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] loss_sum,
  output logic [DATA_W-1:0] loss_mean,
  output logic              sat
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
`ifdef LOSS_MEAN_EN
    DIV,
`endif
    HOLD
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ACC_W-1:0]  acc_next;
  logic [LEN_W-1:0]  cnt_next;

  // Clamp a wide accumulator value to the output width.
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] a);
    return (|a[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : a[DATA_W-1:0];
  endfunction

  // Next accumulator/count values for the beat currently on loss_in.
  always_comb begin
    acc_next = acc + {{(ACC_W-DATA_W){1'b0}}, loss_in};
    cnt_next = cnt + LEN_W'(1);
  end

  assign busy = (state != IDLE);

`ifdef LOSS_MEAN_EN
  localparam int DCNT_W = $clog2(ACC_W + 1);
  localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(ACC_W - 1);

  logic [ACC_W-1:0]  quo;
  logic [LEN_W-1:0]  rem;
  logic [DCNT_W-1:0] div_cnt;
  logic [LEN_W:0]    rem_shift;
  logic              rem_ge;
  logic [ACC_W-1:0]  quo_next;
  logic [LEN_W-1:0]  rem_next;

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  always_comb begin
    rem_shift = {rem, quo[ACC_W-1]};
    rem_ge    = (rem_shift >= {1'b0, len_q});
    quo_next  = {quo[ACC_W-2:0], rem_ge};
    rem_next  = rem_ge ? LEN_W'(rem_shift - {1'b0, len_q}) : rem_shift[LEN_W-1:0];
  end
`else
  assign loss_mean = '0;
`endif

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      loss_sum  <= '0;
      sat       <= 1'b0;
`ifdef LOSS_MEAN_EN
      loss_mean <= '0;
      quo       <= '0;
      rem       <= '0;
      div_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (batch_len != '0) begin
              acc   <= '0;
              cnt   <= '0;
              len_q <= batch_len;
              state <= ACCUM;
            end else begin
              loss_sum  <= '0;
              sat       <= 1'b0;
`ifdef LOSS_MEAN_EN
              loss_mean <= '0;
`endif
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (valid_in) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (cnt_next == len_q) begin
`ifdef LOSS_MEAN_EN
              quo     <= acc_next;
              rem     <= '0;
              div_cnt <= '0;
              state   <= DIV;
`else
              loss_sum  <= saturate(acc_next);
              sat       <= |acc_next[ACC_W-1:DATA_W];
              out_valid <= 1'b1;
              state     <= HOLD;
`endif
            end
          end
        end
`ifdef LOSS_MEAN_EN
        DIV: begin
          quo     <= quo_next;
          rem     <= rem_next;
          div_cnt <= div_cnt + DCNT_W'(1);
          if (div_cnt == DIV_LAST) begin
            loss_mean <= saturate(quo_next);
            loss_sum  <= saturate(acc);
            sat       <= |acc[ACC_W-1:DATA_W];
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
